// File: rtl/regtrace_pkg.sv
// Shared record layout for the writeback-to-trace packer: slot and record structs, slot count type.
package regtrace_pkg;

    localparam int NUM_SLOTS          = 3;
    localparam int DEF_ARCH_LEN       = 32;
    localparam int DEF_NUM_WARPS      = 8;
    localparam int DEF_WARP_ID_BITS   = $clog2(DEF_NUM_WARPS);
    localparam int DEF_NUM_LANES      = 16;
    localparam int DEF_REG_BITS       = 8;
    localparam int DEF_SLOT_DATA_BITS = DEF_NUM_LANES * DEF_ARCH_LEN;

    typedef logic [1:0] cnt_t;
    localparam cnt_t CNT_FULL = cnt_t'(NUM_SLOTS);

    typedef struct packed {
        logic                          enable;
        logic [DEF_REG_BITS-1:0]       address;
        logic [DEF_SLOT_DATA_BITS-1:0] data;
    } slot_t;

    typedef struct packed {
        logic [DEF_ARCH_LEN-1:0]     pc;
        logic [DEF_WARP_ID_BITS-1:0] warp_id;
        slot_t [NUM_SLOTS-1:0]       slots;
    } record_t;

    localparam int REC_BITS = $bits(record_t);

    function automatic slot_t make_slot(input logic [DEF_REG_BITS-1:0]       address,
                                        input logic [DEF_SLOT_DATA_BITS-1:0] data);
        slot_t s;
        s.enable  = 1'b1;
        s.address = address;
        s.data    = data;
        return s;
    endfunction

endpackage

// File: rtl/regtrace_fifo.sv
// Synchronous FIFO of packed trace records; registered storage, head visible combinationally.
// Latency: push in cycle N is visible at head in N+1. Push is ignored when full, pop when empty.
module regtrace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || (1 << PTR_BITS) != DEPTH) begin : g_bad_depth
        $error("regtrace_fifo: DEPTH must be a power of two and at least 2");
    end

    // Extra MSB distinguishes full from empty when the index bits match.
    logic [PTR_BITS:0]  wr_ptr;
    logic [PTR_BITS:0]  rd_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                     (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PTR_BITS-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_BITS+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_BITS+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[PTR_BITS-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/regtrace_packer.sv
// Packs per-beat register writebacks into per-instruction trace records for the difftest sink.
// Latency: last beat accepted in cycle N gives trace_valid in N+1. wb_ready = !fifo_full for every beat.
// REGTRACE_DROP_X0_EN: when defined, enabled writes to register 0 are treated as bookkeeping beats.
module regtrace_packer
    import regtrace_pkg::*;
#(
    parameter int ARCH_LEN  = DEF_ARCH_LEN,
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int REG_BITS  = DEF_REG_BITS,
    parameter int DEPTH     = 4,
    localparam int WARP_ID_BITS = $clog2(NUM_WARPS)
) (
    input  logic                          clock,
    input  logic                          reset,

    input  logic                          wb_valid,
    output logic                          wb_ready,
    input  logic [ARCH_LEN-1:0]           wb_pc,
    input  logic [WARP_ID_BITS-1:0]       wb_warpId,
    input  logic                          wb_enable,
    input  logic [REG_BITS-1:0]           wb_address,
    input  logic [NUM_LANES*ARCH_LEN-1:0] wb_data,
    input  logic                          wb_last,

    output logic                          trace_valid,
    input  logic                          trace_ready,
    output logic [ARCH_LEN-1:0]           trace_pc,
    output logic [WARP_ID_BITS-1:0]       trace_warpId,
    output logic                          trace_regs_0_enable,
    output logic [REG_BITS-1:0]           trace_regs_0_address,
    output logic [NUM_LANES*ARCH_LEN-1:0] trace_regs_0_data,
    output logic                          trace_regs_1_enable,
    output logic [REG_BITS-1:0]           trace_regs_1_address,
    output logic [NUM_LANES*ARCH_LEN-1:0] trace_regs_1_data,
    output logic                          trace_regs_2_enable,
    output logic [REG_BITS-1:0]           trace_regs_2_address,
    output logic [NUM_LANES*ARCH_LEN-1:0] trace_regs_2_data,

    output logic                          empty,
    output logic                          error
);

    if (ARCH_LEN != DEF_ARCH_LEN || NUM_LANES != DEF_NUM_LANES ||
        REG_BITS != DEF_REG_BITS || WARP_ID_BITS != DEF_WARP_ID_BITS) begin : g_bad_params
        $error("regtrace_packer: parameters must match the regtrace_pkg record layout");
    end

    record_t               asm_q;
    logic                  asm_open;
    cnt_t                  asm_cnt;
    logic                  error_q;

    record_t               rec_new;
    record_t               head_rec;
    logic [REC_BITS-1:0]   head_bits;
    logic                  beat_fire;
    logic                  beat_en;
    logic                  slot_free;
    logic                  id_mismatch;
    logic                  overflow;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign wb_ready  = !fifo_full;
    assign beat_fire = wb_valid && wb_ready;

`ifdef REGTRACE_DROP_X0_EN
    assign beat_en = wb_enable && (wb_address != '0);
`else
    assign beat_en = wb_enable;
`endif

    assign slot_free   = (asm_cnt != CNT_FULL);
    assign id_mismatch = asm_open && ((wb_pc != asm_q.pc) || (wb_warpId != asm_q.warp_id));
    assign overflow    = beat_en && !slot_free;
    assign push        = beat_fire && wb_last;
    assign pop         = trace_valid && trace_ready;

    // Record as it stands after this beat; pushed directly when the beat is last.
    always_comb begin
        rec_new = asm_q;
        if (!asm_open) begin
            rec_new.pc      = wb_pc;
            rec_new.warp_id = wb_warpId;
        end
        if (beat_en && slot_free) begin
            rec_new.slots[asm_cnt] = make_slot(wb_address, wb_data);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            asm_q    <= '0;
            asm_open <= 1'b0;
            asm_cnt  <= '0;
            error_q  <= 1'b0;
        end else begin
            if (beat_fire) begin
                if (wb_last) begin
                    asm_q    <= '0;
                    asm_open <= 1'b0;
                    asm_cnt  <= '0;
                end else begin
                    asm_q    <= rec_new;
                    asm_open <= 1'b1;
                    if (beat_en && slot_free) begin
                        asm_cnt <= asm_cnt + cnt_t'(1);
                    end
                end
                if (id_mismatch || overflow) begin
                    error_q <= 1'b1;
                end
            end
        end
    end

    regtrace_fifo #(
        .WIDTH (REC_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (rec_new),
        .pop       (pop),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign trace_valid = !fifo_empty;

    // Data outputs are forced to zero whenever no record is presented.
    always_comb begin
        head_rec = '0;
        if (trace_valid) begin
            head_rec = record_t'(head_bits);
        end
    end

    assign trace_pc             = head_rec.pc;
    assign trace_warpId         = head_rec.warp_id;
    assign trace_regs_0_enable  = head_rec.slots[0].enable;
    assign trace_regs_0_address = head_rec.slots[0].address;
    assign trace_regs_0_data    = head_rec.slots[0].data;
    assign trace_regs_1_enable  = head_rec.slots[1].enable;
    assign trace_regs_1_address = head_rec.slots[1].address;
    assign trace_regs_1_data    = head_rec.slots[1].data;
    assign trace_regs_2_enable  = head_rec.slots[2].enable;
    assign trace_regs_2_address = head_rec.slots[2].address;
    assign trace_regs_2_data    = head_rec.slots[2].data;

    assign empty = fifo_empty && !asm_open && (asm_cnt == '0);
    assign error = error_q;

endmodule

// File: tb/tb_regtrace_packer.sv
// Testbench for regtrace_packer: directed scenarios plus randomized traffic against a queue-based record model.
module tb_regtrace_packer;

    localparam int AL = 32;
    localparam int NL = 16;
    localparam int RB = 8;
    localparam int WB = 3;
    localparam int DW = NL * AL;
`ifdef REGTRACE_DROP_X0_EN
    localparam bit DROP_X0 = 1'b1;
`else
    localparam bit DROP_X0 = 1'b0;
`endif

    typedef struct packed {
        logic [AL-1:0]        pc;
        logic [WB-1:0]        warp;
        logic [2:0]           en;
        logic [2:0][RB-1:0]   addr;
        logic [2:0][DW-1:0]   data;
    } rec_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           wb_valid = 1'b0;
    logic           wb_ready;
    logic [AL-1:0]  wb_pc = '0;
    logic [WB-1:0]  wb_warpId = '0;
    logic           wb_enable = 1'b0;
    logic [RB-1:0]  wb_address = '0;
    logic [DW-1:0]  wb_data = '0;
    logic           wb_last = 1'b0;
    logic           trace_valid;
    logic           trace_ready = 1'b0;
    logic [AL-1:0]  trace_pc;
    logic [WB-1:0]  trace_warpId;
    logic           trace_regs_0_enable, trace_regs_1_enable, trace_regs_2_enable;
    logic [RB-1:0]  trace_regs_0_address, trace_regs_1_address, trace_regs_2_address;
    logic [DW-1:0]  trace_regs_0_data, trace_regs_1_data, trace_regs_2_data;
    logic           empty;
    logic           error;

    regtrace_packer #(
        .ARCH_LEN(AL), .NUM_WARPS(8), .NUM_LANES(NL), .REG_BITS(RB), .DEPTH(4)
    ) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_warpId(wb_warpId),
        .wb_enable(wb_enable), .wb_address(wb_address), .wb_data(wb_data), .wb_last(wb_last),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
        .trace_warpId(trace_warpId),
        .trace_regs_0_enable(trace_regs_0_enable), .trace_regs_0_address(trace_regs_0_address),
        .trace_regs_0_data(trace_regs_0_data),
        .trace_regs_1_enable(trace_regs_1_enable), .trace_regs_1_address(trace_regs_1_address),
        .trace_regs_1_data(trace_regs_1_data),
        .trace_regs_2_enable(trace_regs_2_enable), .trace_regs_2_address(trace_regs_2_address),
        .trace_regs_2_data(trace_regs_2_data),
        .empty(empty), .error(error)
    );

    always #5 clock = ~clock;

    int   vecs = 0;
    int   errs = 0;

    // Reference model: open record, slot count, sticky error, queue of completed records.
    rec_t exp_q[$];
    rec_t m_rec;
    bit   m_open;
    int   m_cnt;
    bit   m_err;

    function automatic void model_clear();
        exp_q.delete();
        m_rec  = '0;
        m_open = 1'b0;
        m_cnt  = 0;
        m_err  = 1'b0;
    endfunction

    function automatic void model_beat(input logic [AL-1:0] pc, input logic [WB-1:0] warp,
                                       input logic en, input logic [RB-1:0] addr,
                                       input logic [DW-1:0] data, input logic last);
        bit stored_write;
        stored_write = en && !(DROP_X0 && addr == 0);
        if (!m_open) begin
            m_open    = 1'b1;
            m_rec.pc   = pc;
            m_rec.warp = warp;
        end else if (pc !== m_rec.pc || warp !== m_rec.warp) begin
            m_err = 1'b1;
        end
        if (stored_write) begin
            if (m_cnt < 3) begin
                m_rec.en[m_cnt]   = 1'b1;
                m_rec.addr[m_cnt] = addr;
                m_rec.data[m_cnt] = data;
                m_cnt++;
            end else begin
                m_err = 1'b1;
            end
        end
        if (last) begin
            exp_q.push_back(m_rec);
            m_rec  = '0;
            m_open = 1'b0;
            m_cnt  = 0;
        end
    endfunction

    function automatic rec_t sample_out();
        rec_t r;
        r.pc      = trace_pc;
        r.warp    = trace_warpId;
        r.en      = {trace_regs_2_enable, trace_regs_1_enable, trace_regs_0_enable};
        r.addr[0] = trace_regs_0_address;
        r.addr[1] = trace_regs_1_address;
        r.addr[2] = trace_regs_2_address;
        r.data[0] = trace_regs_0_data;
        r.data[1] = trace_regs_1_data;
        r.data[2] = trace_regs_2_data;
        return r;
    endfunction

    function automatic string rec_str(input rec_t a, input rec_t b);
        return $sformatf("pc=%h req %h warp=%0d req %0d en=%b req %b addr=%h req %h d0=%h req %h d1=%h req %h d2=%h req %h",
                         a.pc, b.pc, a.warp, b.warp, a.en, b.en, a.addr, b.addr,
                         a.data[0][31:0], b.data[0][31:0], a.data[1][31:0], b.data[1][31:0],
                         a.data[2][31:0], b.data[2][31:0]);
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int g = 0; g < NL; g++) d[AL*g +: AL] = $urandom;
        return d;
    endfunction

    function automatic logic [DW-1:0] ramp_data();
        logic [DW-1:0] d;
        for (int g = 0; g < NL; g++) d[AL*g +: AL] = AL'(g);
        return d;
    endfunction

    task automatic reset_dut();
        @(negedge clock);
        reset       = 1'b1;
        wb_valid    = 1'b0;
        trace_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic send_beat(input logic [AL-1:0] pc, input logic [WB-1:0] warp, input logic en,
                             input logic [RB-1:0] addr, input logic [DW-1:0] data, input logic last);
        int waited = 0;
        @(negedge clock);
        wb_valid = 1'b1; wb_pc = pc; wb_warpId = warp; wb_enable = en;
        wb_address = addr; wb_data = data; wb_last = last;
        while (!wb_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!wb_ready) begin
            vecs++; errs++;
            $display("FAIL beat_accept_timeout wb_ready=%0b required 1", wb_ready);
            wb_valid = 1'b0;
        end else begin
            @(posedge clock);
            model_beat(pc, warp, en, addr, data, last);
            #1 wb_valid = 1'b0;
        end
    endtask

    task automatic pop_record(output rec_t r, output bit got);
        int waited = 0;
        @(negedge clock);
        while (!trace_valid && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        got = trace_valid;
        r   = sample_out();
        if (got) begin
            trace_ready = 1'b1;
            @(posedge clock);
            #1 trace_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rec_t r;
        reset_dut();
        r = sample_out();
        vecs++; if (trace_valid !== 1'b0) begin errs++; $display("FAIL reset_trace_valid got %b req 0", trace_valid); end
        vecs++; if (wb_ready !== 1'b1) begin errs++; $display("FAIL reset_wb_ready got %b req 1", wb_ready); end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b req 1", empty); end
        vecs++; if (error !== 1'b0) begin errs++; $display("FAIL reset_error got %b req 0", error); end
        vecs++; if (r !== rec_t'('0)) begin errs++; $display("FAIL reset_outputs_zero %s", rec_str(r, '0)); end
    endtask

    task automatic test_single_beat();
        rec_t r, e;
        bit   got;
        send_beat(32'h8000_0000, 3'd3, 1'b1, 8'd5, ramp_data(), 1'b1);
        @(negedge clock);
        vecs++; if (trace_valid !== 1'b1) begin errs++; $display("FAIL single_latency trace_valid got %b req 1", trace_valid); end
        e = '0; e.pc = 32'h8000_0000; e.warp = 3'd3; e.en = 3'b001; e.addr[0] = 8'd5; e.data[0] = ramp_data();
        pop_record(r, got);
        vecs++; if (!got || r !== e) begin errs++; $display("FAIL single_record %s", rec_str(r, e)); end
        e = exp_q.pop_front();
        vecs++; if (r !== e) begin errs++; $display("FAIL single_model %s", rec_str(r, e)); end
    endtask

    task automatic test_multi_beat();
        rec_t r, e;
        bit   got;
        for (int i = 1; i <= 3; i++) begin
            send_beat(32'h8000_0100, 3'd1, 1'b1, RB'(i), rand_data(), i == 3);
            if (i == 1) begin
                @(negedge clock);
                vecs++; if (empty !== 1'b0) begin errs++; $display("FAIL multi_empty_open got %b req 0", empty); end
            end
            repeat (2) @(negedge clock);
        end
        pop_record(r, got);
        e = exp_q.pop_front();
        vecs++; if (!got || r !== e) begin errs++; $display("FAIL multi_record %s", rec_str(r, e)); end
        vecs++; if (r.addr !== {8'd3, 8'd2, 8'd1} || r.en !== 3'b111) begin errs++; $display("FAIL multi_slot_order addr=%h req 030201 en=%b req 111", r.addr, r.en); end
        @(negedge clock);
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL multi_empty_after got %b req 1", empty); end
    endtask

    task automatic test_overflow();
        rec_t r, e;
        bit   got;
        for (int i = 0; i < 4; i++) send_beat(32'h8000_0200, 3'd2, 1'b1, RB'(10 + i), rand_data(), i == 3);
        @(negedge clock);
        vecs++; if (error !== 1'b1) begin errs++; $display("FAIL overflow_error got %b req 1", error); end
        pop_record(r, got);
        e = exp_q.pop_front();
        vecs++; if (!got || r !== e) begin errs++; $display("FAIL overflow_record %s", rec_str(r, e)); end
        send_beat(32'h8000_0300, 3'd2, 1'b1, 8'd4, rand_data(), 1'b1);
        pop_record(r, got);
        e = exp_q.pop_front();
        vecs++; if (!got || r !== e) begin errs++; $display("FAIL overflow_next_record %s", rec_str(r, e)); end
        repeat (3) @(negedge clock);
        vecs++; if (error !== 1'b1) begin errs++; $display("FAIL overflow_error_sticky got %b req 1", error); end
    endtask

    task automatic test_pc_mismatch();
        rec_t r, e;
        bit   got;
        reset_dut();
        send_beat(32'h8000_0000, 3'd4, 1'b1, 8'd9, rand_data(), 1'b0);
        @(negedge clock);
        vecs++; if (error !== 1'b0) begin errs++; $display("FAIL pcmis_error_before got %b req 0", error); end
        send_beat(32'h8000_0004, 3'd4, 1'b1, 8'd10, rand_data(), 1'b1);
        @(negedge clock);
        vecs++; if (error !== 1'b1) begin errs++; $display("FAIL pcmis_error got %b req 1", error); end
        pop_record(r, got);
        e = exp_q.pop_front();
        vecs++; if (!got || r !== e || r.pc !== 32'h8000_0000) begin errs++; $display("FAIL pcmis_record %s", rec_str(r, e)); end
    endtask

    task automatic test_reset_mid_record();
        rec_t r, e;
        bit   got;
        send_beat(32'h4000_0000, 3'd5, 1'b1, 8'd21, rand_data(), 1'b0);
        @(negedge clock);
        vecs++; if (empty !== 1'b0) begin errs++; $display("FAIL midreset_empty_open got %b req 0", empty); end
        reset_dut();
        vecs++; if (empty !== 1'b1 || error !== 1'b0) begin errs++; $display("FAIL midreset_state empty=%b req 1 error=%b req 0", empty, error); end
        send_beat(32'h4000_0040, 3'd6, 1'b1, 8'd22, rand_data(), 1'b1);
        pop_record(r, got);
        e = exp_q.pop_front();
        vecs++; if (!got || r !== e) begin errs++; $display("FAIL midreset_record %s", rec_str(r, e)); end
    endtask

    task automatic test_backpressure();
        rec_t r, e;
        bit   got;
        trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(32'h1000 + 32'(i * 4), 3'(i), 1'b1, RB'(30 + i), rand_data(), 1'b1);
        @(negedge clock);
        vecs++; if (wb_ready !== 1'b0) begin errs++; $display("FAIL full_wb_ready got %b req 0", wb_ready); end
        r = sample_out();
        e = exp_q.pop_front();
        vecs++; if (trace_valid !== 1'b1 || r !== e) begin errs++; $display("FAIL full_head valid=%b %s", trace_valid, rec_str(r, e)); end
        trace_ready = 1'b1;
        @(posedge clock);
        #1 trace_ready = 1'b0;
        @(negedge clock);
        vecs++; if (wb_ready !== 1'b1) begin errs++; $display("FAIL pop_wb_ready got %b req 1", wb_ready); end
        send_beat(32'h1010, 3'd7, 1'b0, 8'd0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pop_record(r, got);
            e = exp_q.pop_front();
            vecs++; if (!got || r !== e) begin errs++; $display("FAIL drain_%0d %s", i, rec_str(r, e)); end
        end
    endtask

    task automatic test_back_to_back();
        rec_t r, e;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clock);
            trace_ready = 1'b1;
            if (i > 0) begin
                r = sample_out();
                e = exp_q.pop_front();
                vecs++; if (trace_valid !== 1'b1 || r !== e) begin errs++; $display("FAIL b2b_%0d valid=%b %s", i, trace_valid, rec_str(r, e)); end
            end
            wb_valid = (i < 8);
            wb_pc = 32'h2000 + 32'(i * 4); wb_warpId = 3'(i); wb_enable = i[0];
            wb_address = RB'(40 + i); wb_data = rand_data(); wb_last = 1'b1;
            if (i < 8) begin
                vecs++; if (wb_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_%0d got %b req 1", i, wb_ready); end
            end
            @(posedge clock);
            if (wb_valid && wb_ready) model_beat(wb_pc, wb_warpId, wb_enable, wb_address, wb_data, wb_last);
        end
        #1 wb_valid = 1'b0;
        trace_ready = 1'b0;
        @(negedge clock);
        vecs++; if (trace_valid !== 1'b0) begin errs++; $display("FAIL b2b_drained trace_valid got %b req 0", trace_valid); end
    endtask

    task automatic test_drop_x0();
        rec_t r, e;
        bit   got;
        logic [DW-1:0] d0, d1;
        d0 = rand_data();
        d1 = rand_data();
        send_beat(32'h3000_0000, 3'd1, 1'b1, 8'd0, d0, 1'b0);
        send_beat(32'h3000_0000, 3'd1, 1'b1, 8'd7, d1, 1'b1);
        e = '0; e.pc = 32'h3000_0000; e.warp = 3'd1;
        if (DROP_X0) begin
            e.en = 3'b001; e.addr[0] = 8'd7; e.data[0] = d1;
        end else begin
            e.en = 3'b011; e.addr[0] = 8'd0; e.data[0] = d0; e.addr[1] = 8'd7; e.data[1] = d1;
        end
        pop_record(r, got);
        vecs++; if (!got || r !== e) begin errs++; $display("FAIL x0_record %s", rec_str(r, e)); end
        e = exp_q.pop_front();
        vecs++; if (r !== e) begin errs++; $display("FAIL x0_model %s", rec_str(r, e)); end
    endtask

    task automatic test_random();
        rec_t r, e;
        logic [AL-1:0] rpc;
        logic [WB-1:0] rwarp;
        bit   vld_s, rdy_s, tr;
        reset_dut();
        rpc   = $urandom;
        rwarp = 3'($urandom);
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clock);
            vld_s = trace_valid;
            vecs++; if (vld_s !== (exp_q.size() != 0)) begin errs++; $display("FAIL rnd_valid cyc %0d got %b req %b", cyc, vld_s, exp_q.size() != 0); end
            if (vld_s && exp_q.size() != 0) begin
                r = sample_out();
                e = exp_q[0];
                vecs++; if (r !== e) begin errs++; $display("FAIL rnd_record cyc %0d %s", cyc, rec_str(r, e)); end
            end
            vecs++; if (error !== m_err) begin errs++; $display("FAIL rnd_error cyc %0d got %b req %b", cyc, error, m_err); end
            vecs++; if (empty !== (exp_q.size() == 0 && !m_open)) begin errs++; $display("FAIL rnd_empty cyc %0d got %b req %b", cyc, empty, exp_q.size() == 0 && !m_open); end
            rdy_s = wb_ready;
            vecs++; if (rdy_s !== (exp_q.size() < 4)) begin errs++; $display("FAIL rnd_wb_ready cyc %0d got %b req %b", cyc, rdy_s, exp_q.size() < 4); end
            tr          = ($urandom_range(0, 3) != 0) && (cyc < 480 || 1'b1);
            trace_ready = tr;
            wb_valid    = ($urandom_range(0, 9) < 7) && (cyc < 480);
            wb_pc       = ($urandom_range(0, 29) == 0) ? rpc + 32'd4 : rpc;
            wb_warpId   = rwarp;
            wb_enable   = $urandom_range(0, 3) != 0;
            wb_address  = RB'($urandom_range(0, 7));
            wb_data     = rand_data();
            wb_last     = $urandom_range(0, 2) == 0;
            @(posedge clock);
            if (vld_s && tr) void'(exp_q.pop_front());
            if (wb_valid && rdy_s) begin
                model_beat(wb_pc, wb_warpId, wb_enable, wb_address, wb_data, wb_last);
                if (wb_last) begin
                    rpc   = $urandom;
                    rwarp = 3'($urandom);
                end
            end
            #1 wb_valid = 1'b0;
        end
        trace_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_clear();
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_backpressure();
        test_back_to_back();
        test_drop_x0();
        test_overflow();
        test_pc_mismatch();
        test_reset_mid_record();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
